// File: rtl/operand_entry_ctrl.sv
// operand_entry_ctrl
//   Front end for the 3-bit adder / hex display stage. A bouncy push-button
//   is synchronized and debounced, and each clean press advances a small
//   FSM that captures operand A, then operand B, from the switch bank.
//
//   state   | code | meaning
//   --------+------+-------------------------------------------
//   A_ENTRY |  00  | waiting for press to capture operand A
//   B_ENTRY |  01  | A held on out_0, waiting to capture B
//   SHOW    |  10  | both operands held, sum final (valid_out=1)
//   (none)  |  11  | unreachable; recovers to A_ENTRY, clears all
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   sw_in      3-bit operand switches
//   btn_in     raw push-button, active-high, may bounce
//   clr_in     synchronous clear, active-high, already clean
//   out_0      registered operand A
//   out_1      registered operand B
//   valid_out  registered, high exactly while in SHOW
//   state_out  current FSM state code
module operand_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sw_in,
  input  logic       btn_in,
  input  logic       clr_in,
  output logic [2:0] out_0,
  output logic [2:0] out_1,
  output logic       valid_out,
  output logic [1:0] state_out
);

  typedef enum logic [1:0] {
    A_ENTRY = 2'b00,
    B_ENTRY = 2'b01,
    SHOW    = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // State register kept as a plain 2-bit vector so the unused code 11
  // is representable and its recovery path is well defined.
  logic [1:0]       state_q;
  state_e           state_d;
  logic [2:0]       out_0_d;
  logic [2:0]       out_1_d;
  logic             valid_d;

  logic             sync_0;
  logic             sync;
  logic             db;
  logic             db_prev;
  logic [CNT_W-1:0] cnt;
  logic             press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_0 <= 1'b0;
      sync   <= 1'b0;
    end else begin
      sync_0 <= btn_in;
      sync   <= sync_0;
    end
  end

  // Any cycle where sync agrees with db restarts the count, so only an
  // unbroken run of DEBOUNCE_CYCLES differing samples flips the level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db      <= 1'b0;
      db_prev <= 1'b0;
      cnt     <= '0;
    end else begin
      db_prev <= db;
      if (sync == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= sync;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = db & ~db_prev;

  always_comb begin
    state_d = A_ENTRY;
    out_0_d = out_0;
    out_1_d = out_1;
    case (state_q)
      A_ENTRY: begin
        state_d = A_ENTRY;
        if (press) begin
          out_0_d = sw_in;
          state_d = B_ENTRY;
        end
      end
      B_ENTRY: begin
        state_d = B_ENTRY;
        if (press) begin
          out_1_d = sw_in;
          state_d = SHOW;
        end
      end
      SHOW: begin
        state_d = SHOW;
        if (press) begin
          out_0_d = '0;
          out_1_d = '0;
          state_d = A_ENTRY;
        end
      end
      default: begin
        state_d = A_ENTRY;
        out_0_d = '0;
        out_1_d = '0;
      end
    endcase
    // Clear wins over a coincident press; that press is simply dropped.
    if (clr_in) begin
      state_d = A_ENTRY;
      out_0_d = '0;
      out_1_d = '0;
    end
    valid_d = (state_d == SHOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= 2'b00;
      out_0     <= '0;
      out_1     <= '0;
      valid_out <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_0     <= out_0_d;
      out_1     <= out_1_d;
      valid_out <= valid_d;
    end
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
module tb_operand_entry_ctrl;

  logic       clk;
  logic       rst_n;
  logic [2:0] sw_in;
  logic       btn_in;
  logic       clr_in;
  logic [2:0] out_0;
  logic [2:0] out_1;
  logic       valid_out;
  logic [1:0] state_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       btn;
    logic [2:0] sw;
    logic       clr;
    logic [2:0] e0;
    logic [2:0] e1;
    logic       ev;
    logic [1:0] es;
  } vec_t;

  vec_t vecs[$];

  operand_entry_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_in     (sw_in),
    .btn_in    (btn_in),
    .clr_in    (clr_in),
    .out_0     (out_0),
    .out_1     (out_1),
    .valid_out (valid_out),
    .state_out (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int e0, input int e1,
                           input int ev, input int es);
    check({tag, ".out_0"}, int'(out_0), e0);
    check({tag, ".out_1"}, int'(out_1), e1);
    check({tag, ".valid"}, int'(valid_out), ev);
    check({tag, ".state"}, int'(state_out), es);
  endtask

  // Advance one edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic b, input logic [2:0] s, input logic c,
                     input logic [2:0] e0, input logic [2:0] e1,
                     input logic ev, input logic [1:0] es);
    vec_t v;
    v.btn = b; v.sw = s; v.clr = c; v.e0 = e0; v.e1 = e1; v.ev = ev; v.es = es;
    vecs.push_back(v);
  endtask

  // Full press: hold long enough for one press, then release long enough
  // for the debounced level to fall again.
  task automatic do_press(input logic [2:0] s);
    sw_in  = s;
    btn_in = 1'b1;
    repeat (8) tick();
    btn_in = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    rst_n  = 1'b0;
    sw_in  = 3'd0;
    btn_in = 1'b0;
    clr_in = 1'b0;

    // Row j = inputs before edge j, expected outputs after edge j.
    // btn rises before edge 0, so the capture lands at edge 6.
    for (int i = 0; i < 6; i++)  add(1, 3'd5, 0, 3'd0, 3'd0, 0, 2'b00);
    add(1, 3'd5, 0, 3'd5, 3'd0, 0, 2'b01);
    for (int i = 7; i < 17; i++) add(0, 3'd6, 0, 3'd5, 3'd0, 0, 2'b01);
    for (int i = 17; i < 23; i++) add(1, 3'd6, 0, 3'd5, 3'd0, 0, 2'b01);
    add(1, 3'd6, 0, 3'd5, 3'd6, 1, 2'b10);
    for (int i = 24; i < 34; i++) add(0, 3'd6, 0, 3'd5, 3'd6, 1, 2'b10);

    #12;
    check_all("reset", 0, 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: basic A/B capture with exact latency
    for (int i = 0; i < vecs.size(); i++) begin
      btn_in = vecs[i].btn;
      sw_in  = vecs[i].sw;
      clr_in = vecs[i].clr;
      tick();
      check_all($sformatf("t1[%0d]", i), int'(vecs[i].e0), int'(vecs[i].e1),
                int'(vecs[i].ev), int'(vecs[i].es));
    end

    // clear from SHOW back to A_ENTRY
    clr_in = 1'b1;
    tick();
    clr_in = 1'b0;
    check_all("clr_show", 0, 0, 0, 0);

    // 2: 3-cycle glitches must never register
    sw_in = 3'd7;
    for (int r = 0; r < 5; r++) begin
      btn_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick();
        check(.name($sformatf("t2_hi[%0d].state", r)), .act(int'(state_out)), .exp(0));
      end
      btn_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tick();
        check(.name($sformatf("t2_lo[%0d].state", r)), .act(int'(state_out)), .exp(0));
      end
    end
    repeat (6) tick();
    check_all("t2_end", 0, 0, 0, 0);

    // 3: held button from SHOW gives exactly one transition
    do_press(3'd7);
    do_press(3'd7);
    check_all("t3_show", 7, 7, 1, 2);
    btn_in = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (i < 6) check_all($sformatf("t3[%0d]", i), 7, 7, 1, 2);
      else       check_all($sformatf("t3[%0d]", i), 0, 0, 0, 0);
    end
    btn_in = 1'b0;
    repeat (8) tick();

    // 4: clear coincident with press in B_ENTRY
    do_press(3'd3);
    check_all("t4_b", 3, 0, 0, 1);
    sw_in  = 3'd5;
    btn_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_all($sformatf("t4_wait[%0d]", i), 3, 0, 0, 1);
    end
    clr_in = 1'b1;
    tick();
    clr_in = 1'b0;
    check_all("t4_clr", 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_all($sformatf("t4_after[%0d]", i), 0, 0, 0, 0);
    end
    btn_in = 1'b0;
    repeat (8) tick();

    // 5: async reset mid-cycle, button held through release
    do_press(3'd2);
    do_press(3'd4);
    check_all("t5_show", 2, 4, 1, 2);
    sw_in  = 3'd6;
    btn_in = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_all("t5_async", 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i < 6) check_all($sformatf("t5_deb[%0d]", i), 0, 0, 0, 0);
      else       check_all($sformatf("t5_deb[%0d]", i), 6, 0, 0, 1);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      check_all($sformatf("t5_hold[%0d]", i), 6, 0, 0, 1);
    end
    btn_in = 1'b0;
    repeat (8) tick();

    // 6: illegal state code recovers on the next edge
    do_press(3'd1);
    check_all("t6_show", 6, 1, 1, 2);
    force dut.state_q = 2'b11;
    #1 check("t6_forced.state", int'(state_out), 3);
    release dut.state_q;
    tick();
    check_all("t6_recover", 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_entry_ctrl.md
Name: operand_entry_ctrl

Overview:
Operand-entry front end for the 3-bit adder / hex 7-segment display stage.
- Takes one raw 3-bit switch bank and one raw push-button.
- Debounces the button and steps through a small FSM.
- Captures operand A, then operand B, from the switches on successive presses.
- Holds both operands stable on out_0/out_1, which drive the adder's in_0/in_1 directly.
- Raises valid_out while the displayed sum is final.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive clk cycles the synchronized button must differ from the debounced level before the level flips. Board build overrides to 500000.
CNT_W, 20, debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst_n  input  1  asynchronous, active-low reset
sw_in  input  3  operand switches, unsigned 0..7, assumed quasi-static when sampled
btn_in  input  1  raw push-button, active-high, asynchronous, may bounce
clr_in  input  1  synchronous clear request, active-high, already clean (no debounce)
out_0  output  3  registered operand A (to adder in_0)
out_1  output  3  registered operand B (to adder in_1)
valid_out  output  1  registered; 1 only in state SHOW
state_out  output  2  current FSM state code, for status LEDs

Behaviour:
- Reset: rst_n low asynchronously forces the following to 0, with no clock needed:
  - out_0, out_1, valid_out
  - state_out (state A_ENTRY)
  - both synchronizer flops, the debounced level db, db_prev and the counter
- Synchronizer: btn_in passes through 2 flops to give sync.
- Debounce:
  - When sync == db, the counter is cleared to 0.
  - When sync != db and counter == DEBOUNCE_CYCLES-1, db <= sync and the counter is cleared.
  - Otherwise, when sync != db, the counter increments.
  - Result: db flips on the DEBOUNCE_CYCLES-th consecutive differing edge. Shorter glitches are fully rejected.
- Press detect:
  - db_prev is a register of db.
  - press = db & ~db_prev, a single-cycle pulse.
  - A held button yields exactly one pulse. Release yields none.
- Latency: if btn_in rises just before edge k and stays high:
  - sync is high after edge k+1.
  - db rises at edge k+1+DEBOUNCE_CYCLES.
  - The FSM acts at edge k+2+DEBOUNCE_CYCLES, sampling sw_in in the cycle before that edge.
- FSM states (state_out code):
  - A_ENTRY (00):
    - press: out_0 <= sw_in, go B_ENTRY.
  - B_ENTRY (01):
    - press: out_1 <= sw_in, go SHOW.
  - SHOW (10):
    - valid_out = 1.
    - press: out_0 <= 0, out_1 <= 0, go A_ENTRY.
  - Code 11: unreachable. If entered, return to A_ENTRY on the next edge with out_0, out_1 and valid_out cleared.
- Outputs are registered; no combinational path from inputs to outputs.
- valid_out is registered and asserted exactly while state is SHOW.
- Operands are never modified except as listed. out_0 holds its value through B_ENTRY and SHOW.
- clr_in:
  - At any edge: state <= A_ENTRY, out_0 <= 0, out_1 <= 0, valid_out <= 0.
  - Has priority over a simultaneous press; that press is consumed and has no other effect.
  - Does not reset the debouncer.
- Width: operands are 3-bit unsigned. Downstream sum range is 0..14 and fits its 4-bit intermediate.
- Reset mid-debounce discards the partial count. A button still held at reset release must go through a full debounce before it counts, then produces one press.

Test Plan:
1. DEBOUNCE_CYCLES=4, reset.
   - Drive sw_in=5 and press; release, sw_in=6, press.
   - Required: out_0=5, then out_1=6, state_out=10, valid_out=1.
   - FSM update lands exactly at edge k+6 after each btn_in rise.
2. In A_ENTRY, toggle btn_in high for 3 cycles then low, repeated 5 times.
   - Required: no press; state_out stays 00; out_0 stays 0.
3. From SHOW (out_0=7, out_1=7), hold btn_in high for 50 cycles.
   - Required: exactly one transition to A_ENTRY; out_0=out_1=0; valid_out falls at the same edge.
4. In B_ENTRY with out_0=3, assert clr_in in the same cycle as the press pulse.
   - Required: state_out=00, out_0=out_1=0; sw_in is not captured.
5. Assert rst_n low mid-clock-cycle during SHOW.
   - Required: all outputs 0 immediately, before the next edge.
   - Then hold btn high through reset release: one press after 2+DEBOUNCE_CYCLES edges captures sw_in into out_0.
6. Force state code 11 via the bench.
   - Required: the next edge gives state_out=00, valid_out=0.
